// File: rtl/noc_switch3_pkt.sv
// noc_switch3_pkt: 3-port packet-aware NoC switch (1=top, 2=bottom, 3=right).
// Each input buffers flits in a small FWFT FIFO; each output owns a round-robin
// arbiter that holds its grant from a packet's head flit until its last flit.
// Optional build macro SWITCH_STATS_EN adds one 16-bit delivered-packet counter
// per output (o_pkt_cnt1..3).
//
// Arbiter states (one arbiter per output):
//   state | meaning
//   IDLE  | no owner; looks for head flits routed to this output
//   BUSY  | owner's packet streams out until a transfer with last
//
// Route ranges must satisfy min <= max; top wins where ranges overlap.
module noc_switch3_pkt #(
    parameter int DataWidth = 32,
    parameter int FifoDepth = 4,
    parameter int DestLsb   = 24,
    parameter int DestWidth = 8,
    parameter int topMin    = 1,
    parameter int topMax    = 1,
    parameter int bottomMin = 0,
    parameter int bottomMax = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DataWidth-1:0] i_data1,
    input  logic                 i_data_last1,
    input  logic                 i_data_valid1,
    output logic                 o_data_ready1,
    output logic [DataWidth-1:0] o_data1,
    output logic                 o_data_last1,
    output logic                 o_data_valid1,
    input  logic                 i_data_ready1,
    input  logic [DataWidth-1:0] i_data2,
    input  logic                 i_data_last2,
    input  logic                 i_data_valid2,
    output logic                 o_data_ready2,
    output logic [DataWidth-1:0] o_data2,
    output logic                 o_data_last2,
    output logic                 o_data_valid2,
    input  logic                 i_data_ready2,
    input  logic [DataWidth-1:0] i_data3,
    input  logic                 i_data_last3,
    input  logic                 i_data_valid3,
    output logic                 o_data_ready3,
    output logic [DataWidth-1:0] o_data3,
    output logic                 o_data_last3,
    output logic                 o_data_valid3,
    input  logic                 i_data_ready3
`ifdef SWITCH_STATS_EN
    ,
    output logic [15:0]          o_pkt_cnt1,
    output logic [15:0]          o_pkt_cnt2,
    output logic [15:0]          o_pkt_cnt3
`endif
);

    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;

    // Ranges are checked as (d - min) <= (max - min) in DestWidth-bit arithmetic,
    // which avoids constant-true comparisons when a min is zero.
    localparam logic [DestWidth-1:0] TOP_MIN  = DestWidth'(topMin);
    localparam logic [DestWidth-1:0] TOP_SPAN = DestWidth'(topMax - topMin);
    localparam logic [DestWidth-1:0] BOT_MIN  = DestWidth'(bottomMin);
    localparam logic [DestWidth-1:0] BOT_SPAN = DestWidth'(bottomMax - bottomMin);

    typedef enum logic {IDLE, BUSY} arb_state_t;

    logic [DataWidth-1:0] in_data [3];
    logic [2:0]           in_last, in_valid, in_ready, dn_ready;

    logic [DataWidth-1:0] mem_data [3][FifoDepth];
    logic                 mem_last [3][FifoDepth];
    logic [AW-1:0]        wr_ptr [3];
    logic [AW-1:0]        rd_ptr [3];
    logic [CW-1:0]        count [3];
    logic [2:0]           push, pop, empty, is_head, head_last;
    logic [DataWidth-1:0] head_data [3];
    logic [1:0]           route [3];
    logic [2:0]           req [3];

    arb_state_t           state [3];
    arb_state_t           state_next [3];
    logic [1:0]           owner [3];
    logic [1:0]           owner_next [3];
    logic [1:0]           rr [3];
    logic [1:0]           rr_next [3];

    logic [DataWidth-1:0] out_data [3];
    logic [2:0]           out_last, out_valid, xfer;

    assign in_data[0] = i_data1;
    assign in_data[1] = i_data2;
    assign in_data[2] = i_data3;
    assign in_last    = {i_data_last3, i_data_last2, i_data_last1};
    assign in_valid   = {i_data_valid3, i_data_valid2, i_data_valid1};
    assign dn_ready   = {i_data_ready3, i_data_ready2, i_data_ready1};

    assign o_data_ready1 = in_ready[0];
    assign o_data_ready2 = in_ready[1];
    assign o_data_ready3 = in_ready[2];
    assign o_data1       = out_data[0];
    assign o_data2       = out_data[1];
    assign o_data3       = out_data[2];
    assign o_data_last1  = out_last[0];
    assign o_data_last2  = out_last[1];
    assign o_data_last3  = out_last[2];
    assign o_data_valid1 = out_valid[0];
    assign o_data_valid2 = out_valid[1];
    assign o_data_valid3 = out_valid[2];

    function automatic logic [1:0] route_of(input logic [DestWidth-1:0] d);
        logic [DestWidth-1:0] top_off;
        logic [DestWidth-1:0] bot_off;
        top_off = d - TOP_MIN;
        bot_off = d - BOT_MIN;
        if (top_off <= TOP_SPAN)
            route_of = 2'd0;
        else if (bot_off <= BOT_SPAN)
            route_of = 2'd1;
        else
            route_of = 2'd2;
    endfunction

    // First requester strictly after the pointer, order 1->2->3->1.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (r[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // FIFO status, head view, route decode of the head flit and per-output requests.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_ready[i]  = (count[i] != CW'(FifoDepth)) & ~i_reset;
            push[i]      = in_valid[i] & in_ready[i];
            empty[i]     = (count[i] == '0);
            head_data[i] = mem_data[i][rd_ptr[i]];
            head_last[i] = mem_last[i][rd_ptr[i]];
            route[i]     = route_of(head_data[i][DestLsb +: DestWidth]);
        end
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                req[o][i] = ~empty[i] & is_head[i] & (route[i] == 2'(o));
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i]] <= in_data[i];
                mem_last[i][wr_ptr[i]] <= in_last[i];
            end
        end
    end

    // FIFO pointers, occupancy and head-flit tracking (next flit after a last is a head).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
                count[i]   <= '0;
                is_head[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i]) begin
                    rd_ptr[i]  <= rd_ptr[i] + 1'b1;
                    is_head[i] <= head_last[i];
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // Arbiter state register; pointer 2 (input 3) gives input 1 first priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int o = 0; o < 3; o++) begin
                state[o] <= IDLE;
                owner[o] <= 2'd0;
                rr[o]    <= 2'd2;
            end
        end else begin
            for (int o = 0; o < 3; o++) begin
                state[o] <= state_next[o];
                owner[o] <= owner_next[o];
                rr[o]    <= rr_next[o];
            end
        end
    end

    // Arbiter next state: grant on a routed head flit, release after the last transfer.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            state_next[o] = state[o];
            owner_next[o] = owner[o];
            rr_next[o]    = rr[o];
            case (state[o])
                IDLE: begin
                    if (|req[o]) begin
                        state_next[o] = BUSY;
                        owner_next[o] = rr_pick(req[o], rr[o]);
                    end
                end
                BUSY: begin
                    if (xfer[o] && out_last[o]) begin
                        state_next[o] = IDLE;
                        rr_next[o]    = owner[o];
                    end
                end
                default: state_next[o] = IDLE;
            endcase
        end
    end

    // Output drive from the owner's FIFO head; data/last forced to zero when not valid.
    always_comb begin
        pop = '0;
        for (int o = 0; o < 3; o++) begin
            out_valid[o] = (state[o] == BUSY) & ~empty[owner[o]];
            out_data[o]  = out_valid[o] ? head_data[owner[o]] : '0;
            out_last[o]  = out_valid[o] & head_last[owner[o]];
            xfer[o]      = out_valid[o] & dn_ready[o];
            for (int i = 0; i < 3; i++) begin
                if (xfer[o] && owner[o] == 2'(i))
                    pop[i] = 1'b1;
            end
        end
    end

`ifdef SWITCH_STATS_EN
    logic [15:0] pkt_cnt [3];

    // Delivered-packet counters, one per output, wrapping at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int o = 0; o < 3; o++)
                pkt_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (xfer[o] && out_last[o])
                    pkt_cnt[o] <= pkt_cnt[o] + 16'd1;
            end
        end
    end

    assign o_pkt_cnt1 = pkt_cnt[0];
    assign o_pkt_cnt2 = pkt_cnt[1];
    assign o_pkt_cnt3 = pkt_cnt[2];
`endif

endmodule

// File: tb/tb_noc_switch3_pkt.sv
// Directed bench for noc_switch3_pkt: expected flits are queued per output when
// stimulus is driven and checked in order as each output transfers.
module tb_noc_switch3_pkt;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din [3];
    logic [31:0] dout [3];
    logic [2:0]  dlast, dvalid, rdy, olast, ovalid, dn_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    flit_t q0[$];
    flit_t q1[$];
    flit_t q2[$];
    int    exp_cnt [3];

    logic        prev_stall [3];
    logic [31:0] prev_d [3];
    logic        prev_l [3];

`ifdef SWITCH_STATS_EN
    logic [15:0] pkt_cnt [3];
`endif

    noc_switch3_pkt dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_data1       (din[0]),
        .i_data_last1  (dlast[0]),
        .i_data_valid1 (dvalid[0]),
        .o_data_ready1 (rdy[0]),
        .o_data1       (dout[0]),
        .o_data_last1  (olast[0]),
        .o_data_valid1 (ovalid[0]),
        .i_data_ready1 (dn_rdy[0]),
        .i_data2       (din[1]),
        .i_data_last2  (dlast[1]),
        .i_data_valid2 (dvalid[1]),
        .o_data_ready2 (rdy[1]),
        .o_data2       (dout[1]),
        .o_data_last2  (olast[1]),
        .o_data_valid2 (ovalid[1]),
        .i_data_ready2 (dn_rdy[1]),
        .i_data3       (din[2]),
        .i_data_last3  (dlast[2]),
        .i_data_valid3 (dvalid[2]),
        .o_data_ready3 (rdy[2]),
        .o_data3       (dout[2]),
        .o_data_last3  (olast[2]),
        .o_data_valid3 (ovalid[2]),
        .i_data_ready3 (dn_rdy[2])
`ifdef SWITCH_STATS_EN
        ,
        .o_pkt_cnt1    (pkt_cnt[0]),
        .o_pkt_cnt2    (pkt_cnt[1]),
        .o_pkt_cnt3    (pkt_cnt[2])
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int o);
        case (o)
            0:       q_size = q0.size();
            1:       q_size = q1.size();
            default: q_size = q2.size();
        endcase
    endfunction

    task automatic q_push(input int o, input logic [31:0] d, input logic l);
        flit_t f;
        f.d = d;
        f.l = l;
        case (o)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
        if (l) exp_cnt[o]++;
    endtask

    task automatic q_pop(input int o, output flit_t f);
        case (o)
            0:       f = q0.pop_front();
            1:       f = q1.pop_front();
            default: f = q2.pop_front();
        endcase
    endtask

    task automatic mon_port(input int o);
        flit_t e;
        if (prev_stall[o]) begin
            chk($sformatf("out%0d_hold_valid", o + 1), ovalid[o], 1'b1);
            chk($sformatf("out%0d_hold_data", o + 1), dout[o], prev_d[o]);
            chk($sformatf("out%0d_hold_last", o + 1), olast[o], prev_l[o]);
        end
        if (ovalid[o]) begin
            if (dn_rdy[o]) begin
                if (q_size(o) == 0) begin
                    chk($sformatf("out%0d_unexpected_flit", o + 1), ovalid[o], 1'b0);
                end else begin
                    q_pop(o, e);
                    chk($sformatf("out%0d_data", o + 1), dout[o], e.d);
                    chk($sformatf("out%0d_last", o + 1), olast[o], e.l);
                end
            end
        end else begin
            chk($sformatf("out%0d_idle_data", o + 1), dout[o], 32'h0);
            chk($sformatf("out%0d_idle_last", o + 1), olast[o], 1'b0);
        end
        prev_stall[o] = ovalid[o] & ~dn_rdy[o];
        prev_d[o]     = dout[o];
        prev_l[o]     = olast[o];
    endtask

    // Output monitor: sampled mid-cycle, so values match what the next edge transfers.
    always @(negedge clk) begin
        if (rst) begin
            for (int o = 0; o < 3; o++) prev_stall[o] = 1'b0;
        end else begin
            for (int o = 0; o < 3; o++) mon_port(o);
        end
    end

    task automatic drive(input logic [2:0] m,
                         input logic [31:0] d0, input logic l0,
                         input logic [31:0] d1, input logic l1,
                         input logic [31:0] d2, input logic l2);
        int n = 0;
        while (((rdy & m) != m) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", rdy & m, m);
        din[0] = d0; din[1] = d1; din[2] = d2;
        dlast  = {l2, l1, l0};
        dvalid = m;
        @(posedge clk); #1;
        dvalid = 3'b000;
        dlast  = 3'b000;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q_size(0) + q_size(1) + q_size(2), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef SWITCH_STATS_EN
        for (int o = 0; o < 3; o++)
            chk($sformatf("pkt_cnt%0d", o + 1), pkt_cnt[o], 16'(exp_cnt[o]));
`endif
    endtask

    initial begin
        rst    = 1'b1;
        dvalid = 3'b000;
        dlast  = 3'b000;
        dn_rdy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            din[i]        = 32'h0;
            exp_cnt[i]    = 0;
            prev_stall[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 3'b000);
        chk("rst_valid", ovalid, 3'b000);
        chk("rst_out1_data", dout[0], 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rdy, 3'b111);
        check_stats();
        @(posedge clk); #1;

        // Single-flit packet in1 -> out2 with minimum latency.
        q_push(1, 32'h00AABBCC, 1'b1);
        drive(3'b001, 32'h00AABBCC, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("lat_t1_valid", ovalid, 3'b000);
        @(posedge clk); #1;
        chk("lat_t2_valid", ovalid, 3'b010);
        chk("lat_t2_data", dout[1], 32'h00AABBCC);
        chk("lat_t2_last", olast[1], 1'b1);
        wait_drain();

        // in2 three-flit packet to out1; body dest bits must be ignored.
        q_push(0, 32'h01000021, 1'b0);
        q_push(0, 32'h05000022, 1'b0);
        q_push(0, 32'h05000023, 1'b1);
        drive(3'b010, 32'h0, 1'b0, 32'h01000021, 1'b0, 32'h0, 1'b0);
        drive(3'b010, 32'h0, 1'b0, 32'h05000022, 1'b0, 32'h0, 1'b0);
        drive(3'b010, 32'h0, 1'b0, 32'h05000023, 1'b1, 32'h0, 1'b0);
        wait_drain();

        // All inputs to out3 at once, two rounds: order in1,in2,in3 then again.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                q_push(2, 32'h07000000 | 32'((i + 1) << 8) | 32'(r << 4) | 32'h0, 1'b0);
                q_push(2, 32'h01000000 | 32'((i + 1) << 8) | 32'(r << 4) | 32'h1, 1'b1);
            end
            drive(3'b111, 32'h07000100 | 32'(r << 4), 1'b0,
                          32'h07000200 | 32'(r << 4), 1'b0,
                          32'h07000300 | 32'(r << 4), 1'b0);
            drive(3'b111, 32'h01000101 | 32'(r << 4), 1'b1,
                          32'h01000201 | 32'(r << 4), 1'b1,
                          32'h01000301 | 32'(r << 4), 1'b1);
        end
        wait_drain();

        // out1 pointer now at in2: simultaneous single flits go in3, in1, in2.
        q_push(0, 32'h01000C03, 1'b1);
        q_push(0, 32'h01000C01, 1'b1);
        q_push(0, 32'h01000C02, 1'b1);
        drive(3'b111, 32'h01000C01, 1'b1, 32'h01000C02, 1'b1, 32'h01000C03, 1'b1);
        wait_drain();

        // out2 stalled mid-packet for 5 cycles while in1 -> out1 proceeds.
        q_push(0, 32'h01005501, 1'b0);
        q_push(0, 32'h01005502, 1'b0);
        q_push(0, 32'h01005503, 1'b1);
        q_push(1, 32'h00006601, 1'b0);
        q_push(1, 32'h00006602, 1'b0);
        q_push(1, 32'h00006603, 1'b0);
        q_push(1, 32'h00006604, 1'b1);
        drive(3'b101, 32'h01005501, 1'b0, 32'h0, 1'b0, 32'h00006601, 1'b0);
        drive(3'b101, 32'h01005502, 1'b0, 32'h0, 1'b0, 32'h00006602, 1'b0);
        drive(3'b101, 32'h01005503, 1'b1, 32'h0, 1'b0, 32'h00006603, 1'b0);
        drive(3'b100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h00006604, 1'b1);
        dn_rdy[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_out1_done", q_size(0), 0);
        chk("stall_out2_pending", q_size(1), 2);
        chk("stall_out2_valid", ovalid[1], 1'b1);
        chk("stall_out2_data", dout[1], 32'h00006603);
        dn_rdy[1] = 1'b1;
        wait_drain();

        // in1 fills its FIFO while out3 is blocked.
        dn_rdy[2] = 1'b0;
        q_push(2, 32'h07007701, 1'b0);
        q_push(2, 32'h07007702, 1'b0);
        q_push(2, 32'h07007703, 1'b0);
        q_push(2, 32'h07007704, 1'b1);
        drive(3'b001, 32'h07007701, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(3'b001, 32'h07007702, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(3'b001, 32'h07007703, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("fill_ready_after3", rdy[0], 1'b1);
        drive(3'b001, 32'h07007704, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("fill_ready_after4", rdy[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("fill_ready_held", rdy[0], 1'b0);
        chk("fill_out3_valid", ovalid[2], 1'b1);
        dn_rdy[2] = 1'b1;
        #1;
        chk("fill_pop_cycle_ready", rdy[0], 1'b0);
        wait_drain();
        check_stats();

        // Reset with a partial packet of 3 flits buffered toward out2.
        dn_rdy[1] = 1'b0;
        drive(3'b001, 32'h00008801, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(3'b001, 32'h07008802, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(3'b001, 32'h07008803, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("prerst_out2_valid", ovalid[1], 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", rdy, 3'b000);
        @(posedge clk); #1;
        chk("midrst_valid", ovalid, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        dn_rdy = 3'b111;
        #1;
        chk("postrst_ready", rdy, 3'b111);
        check_stats();
        q_push(2, 32'h07009901, 1'b1);
        q_push(0, 32'h01009902, 1'b1);
        drive(3'b011, 32'h07009901, 1'b1, 32'h01009902, 1'b1, 32'h0, 1'b0);
        wait_drain();
        check_stats();

        chk("final_q_out1", q_size(0), 0);
        chk("final_q_out2", q_size(1), 0);
        chk("final_q_out3", q_size(2), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
